// File: rtl/shift_cmd_sequencer_pkg.sv
// Shared definitions for the shift command sequencer.
//   op codes  : command encodings on cmd_op (6 and 7 decode as HOLD)
//   ST_*      : sequencer FSM states
//   isrc_e    : selector for the serial input i driven to the register
package shift_cmd_sequencer_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHU  = 3'd2,
      OP_SHD  = 3'd3,
      OP_ROU  = 3'd4,
      OP_ROD  = 3'd5
   } op_e;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   typedef enum logic [1:0] {
      ISRC_ZERO,
      ISRC_FILL,
      ISRC_MSB,
      ISRC_LSB
   } isrc_e;

endpackage

// File: rtl/shift_cmd_sequencer_step_counter.sv
// Loadable down-counter that tracks the remaining steps of the current command.
//   c        : clock, rising edge
//   rst      : synchronous reset, active high (clears rem)
//   load     : load load_val into rem (wins over dec)
//   load_val : step count to load
//   dec      : decrement rem by one (saturates at zero)
//   rem      : remaining steps
//   last     : rem == 1, the current edge is the final step
module shift_cmd_sequencer_step_counter #(
   parameter int unsigned CW = 4
) (
   input  logic          c,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic [CW-1:0] rem,
   output logic          last
);

   logic [CW-1:0] rem_q;

   always_ff @(posedge c) begin
      if (rst) begin
         rem_q <= '0;
      end else if (load) begin
         rem_q <= load_val;
      end else if (dec && (rem_q != '0)) begin
         rem_q <= rem_q - CW'(1);
      end
   end

   assign rem  = rem_q;
   assign last = (rem_q == CW'(1));

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer for the N-bit universal shift register. Accepts one command per
// valid/ready handshake and expands it into per-cycle register controls.
//   c, rst     : clock (rising edge), synchronous active-high reset
//   cmd_valid  : command present;  cmd_ready : command accepted when both high
//   cmd_op     : HOLD/LOAD/SHU/SHD/ROU/ROD (6,7 act as HOLD)
//   cmd_cnt    : step count for shift/rotate; cmd_fill : serial fill bit
//   cmd_data   : parallel load value;  q_fb : register contents for rotates
//   l, r, i, d : register controls (l=r=1 load, l only SHD, r only SHU)
//   busy       : command in progress;  done : one-cycle completion pulse
module shift_cmd_sequencer
   import shift_cmd_sequencer_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned CW = $clog2(N) + 1
) (
   input  logic          c,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [CW-1:0] cmd_cnt,
   input  logic          cmd_fill,
   input  logic [N-1:0]  cmd_data,
   input  logic [N-1:0]  q_fb,
   output logic          l,
   output logic          r,
   output logic          i,
   output logic [N-1:0]  d,
   output logic          busy,
   output logic          done
);

   logic [0:0]    state_q;
   logic          l_q, r_q, fill_q, done_q;
   logic [N-1:0]  d_q;
   isrc_e         isrc_q;

   logic [CW-1:0] rem;
   logic          last;
   logic          run_last;
   logic          accept;

   logic          dec_run, dec_l, dec_r;
   isrc_e         dec_isrc;
   logic [CW-1:0] dec_steps;
   logic          has_cnt;

   // Decode the offered command; dec_run=0 means it completes without control cycles.
   always_comb begin
      dec_run   = 1'b0;
      dec_l     = 1'b0;
      dec_r     = 1'b0;
      dec_isrc  = ISRC_ZERO;
      dec_steps = cmd_cnt;
      has_cnt   = (cmd_cnt != '0);
      case (cmd_op)
         OP_LOAD: begin
            dec_run   = 1'b1;
            dec_l     = 1'b1;
            dec_r     = 1'b1;
            dec_steps = CW'(1);
         end
         OP_SHU: begin
            dec_run  = has_cnt;
            dec_r    = 1'b1;
            dec_isrc = ISRC_FILL;
         end
         OP_SHD: begin
            dec_run  = has_cnt;
            dec_l    = 1'b1;
            dec_isrc = ISRC_FILL;
         end
         OP_ROU: begin
            dec_run  = has_cnt;
            dec_r    = 1'b1;
            dec_isrc = ISRC_MSB;
         end
         OP_ROD: begin
            dec_run  = has_cnt;
            dec_l    = 1'b1;
            dec_isrc = ISRC_LSB;
         end
         default: ;
      endcase
   end

   assign run_last  = (state_q == ST_RUN) && last;
   // Ready on the final step too, so a queued command follows with no bubble.
   assign cmd_ready = !rst && ((state_q == ST_IDLE) || run_last);
   assign accept    = cmd_valid && cmd_ready;

   shift_cmd_sequencer_step_counter #(
      .CW (CW)
   ) u_step_counter (
      .c        (c),
      .rst      (rst),
      .load     (accept && dec_run),
      .load_val (dec_steps),
      .dec      (state_q == ST_RUN),
      .rem      (rem),
      .last     (last)
   );

   always_ff @(posedge c) begin
      if (rst) begin
         state_q <= ST_IDLE;
         l_q     <= 1'b0;
         r_q     <= 1'b0;
         fill_q  <= 1'b0;
         isrc_q  <= ISRC_ZERO;
         d_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= run_last || (accept && !dec_run);
         if (accept && dec_run) begin
            state_q <= ST_RUN;
            l_q     <= dec_l;
            r_q     <= dec_r;
            isrc_q  <= dec_isrc;
            fill_q  <= cmd_fill;
            if (cmd_op == OP_LOAD) begin
               d_q <= cmd_data;
            end
         end else if (accept || run_last) begin
            // Trivial command or end of run: back to hold, d keeps its value.
            state_q <= ST_IDLE;
            l_q     <= 1'b0;
            r_q     <= 1'b0;
            isrc_q  <= ISRC_ZERO;
         end
      end
   end

   // Rotates take the serial bit straight from the live register contents.
   always_comb begin
      i = 1'b0;
      unique case (isrc_q)
         ISRC_ZERO: i = 1'b0;
         ISRC_FILL: i = fill_q;
         ISRC_MSB:  i = q_fb[N-1];
         ISRC_LSB:  i = q_fb[0];
      endcase
   end

   assign l    = l_q;
   assign r    = r_q;
   assign d    = d_q;
   assign busy = (state_q == ST_RUN);
   assign done = done_q;

   logic unused_rem;
   assign unused_rem = ^rem;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
module tb_shift_cmd_sequencer;

   localparam int N  = 8;
   localparam int CW = 4;

   logic          c = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [CW-1:0] cmd_cnt;
   logic          cmd_fill;
   logic [N-1:0]  cmd_data;
   logic [N-1:0]  q = '0;
   logic          l, r, i, busy, done;
   logic [N-1:0]  d;

   int vectors = 0;
   int miscompares = 0;
   logic [N-1:0] exp_q = '0;

   always #5 c = ~c;

   shift_cmd_sequencer #(.N(N), .CW(CW)) dut (
      .c         (c),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_cnt   (cmd_cnt),
      .cmd_fill  (cmd_fill),
      .cmd_data  (cmd_data),
      .q_fb      (q),
      .l         (l),
      .r         (r),
      .i         (i),
      .d         (d),
      .busy      (busy),
      .done      (done)
   );

   // Universal shift register driven by the sequencer.
   always @(posedge c) begin
      if (l && r)  q <= d;
      else if (l)  q <= {i, q[N-1:1]};
      else if (r)  q <= {q[N-2:0], i};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One register step of the reference model, by arithmetic on the value.
   function automatic logic [N-1:0] model_step(input int op, input logic fill,
                                              input logic [N-1:0] v);
      int x;
      x = int'(v);
      case (op)
         2: x = (x * 2) % 256 + int'(fill);
         3: x = x / 2 + int'(fill) * 128;
         4: x = (x * 2) % 256 + x / 128;
         5: x = x / 2 + (x % 2) * 128;
         default: ;
      endcase
      return N'(x);
   endfunction

   // Issue one command and check every cycle until its done pulse.
   task automatic run_cmd(input int op, input int cnt, input logic fill, input logic [N-1:0] data);
      int k, n;
      logic el, er, ei;
      k = (op == 1) ? 1 : ((op >= 2 && op <= 5) ? cnt : 0);
      @(negedge c);
      cmd_valid = 1'b1;
      cmd_op    = 3'(op);
      cmd_cnt   = CW'(cnt);
      cmd_fill  = fill;
      cmd_data  = data;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge c);
         n++;
      end
      if (!cmd_ready) chk("ready_timeout", 0, 1);
      @(posedge c);
      #1 cmd_valid = 1'b0;
      for (int s = 0; s < k; s++) begin
         @(negedge c);
         el = (op == 1) || (op == 3) || (op == 5);
         er = (op == 1) || (op == 2) || (op == 4);
         ei = (op == 2 || op == 3) ? fill : (op == 4) ? exp_q[N-1] : (op == 5) ? exp_q[0] : 1'b0;
         chk($sformatf("run_ctl op%0d s%0d", op, s), {l, r, i, busy, done}, {el, er, ei, 2'b10});
         if (op == 1) begin
            chk("load_d", d, data);
            exp_q = data;
         end else begin
            exp_q = model_step(op, fill, exp_q);
         end
      end
      @(negedge c);
      chk($sformatf("done_ctl op%0d k%0d", op, k), {l, r, i, busy, done}, 5'b00001);
      chk($sformatf("q op%0d", op), q, exp_q);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = '0;
      cmd_cnt = '0;
      cmd_fill = 1'b0;
      cmd_data = '0;
      repeat (2) @(posedge c);
      @(negedge c);
      chk("rst_outs", {l, r, i, busy, done}, 5'b0);
      chk("rst_d", d, 0);
      chk("rst_ready", cmd_ready, 0);
      rst = 1'b0;
      #1 chk("ready_after_rst", cmd_ready, 1);

      run_cmd(1, 0, 1'b0, 8'hA5);
      run_cmd(3, 3, 1'b1, 8'h00);
      chk("shd_q", q, 8'hF4);
      run_cmd(1, 0, 1'b0, 8'hA5);
      run_cmd(4, 3, 1'b0, 8'h00);
      chk("rou_q", q, 8'h2D);
      run_cmd(1, 0, 1'b0, 8'hA5);

      // Back-to-back: LOAD held valid behind SHU cnt=2.
      @(negedge c);
      cmd_valid = 1'b1; cmd_op = 3'd2; cmd_cnt = CW'(2); cmd_fill = 1'b0;
      @(posedge c);
      #1 cmd_op = 3'd1; cmd_data = 8'h3C;
      @(negedge c);
      chk("b2b_c1", {l, r, busy, cmd_ready, done}, 5'b01100);
      @(negedge c);
      chk("b2b_c2", {l, r, busy, cmd_ready, done}, 5'b01110);
      @(posedge c);
      #1 cmd_valid = 1'b0;
      @(negedge c);
      chk("b2b_c3", {l, r, busy, done}, 4'b1111);
      chk("b2b_d", d, 8'h3C);
      chk("b2b_q_mid", q, 8'h94);
      @(negedge c);
      chk("b2b_c4", {l, r, busy, done}, 4'b0001);
      chk("b2b_q", q, 8'h3C);
      exp_q = 8'h3C;

      run_cmd(0, 5, 1'b1, 8'hFF);
      run_cmd(3, 0, 1'b1, 8'hFF);
      run_cmd(7, 3, 1'b1, 8'hFF);

      // Reset during the third RUN cycle of SHD cnt=8.
      @(negedge c);
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_cnt = CW'(8); cmd_fill = 1'b1;
      @(posedge c);
      #1 cmd_valid = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge c);
         chk("abort_run", {l, r, i, busy}, 4'b1011);
         exp_q = model_step(3, 1'b1, exp_q);
      end
      rst = 1'b1;
      #1 chk("abort_ready", cmd_ready, 0);
      @(negedge c);
      chk("abort_outs", {l, r, i, busy, done}, 5'b0);
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge c);
         chk("abort_quiet", {l, r, busy, done}, 4'b0);
      end
      chk("abort_q", q, exp_q);

      for (int t = 0; t < 40; t++) begin
         run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 11)),
                 1'($urandom_range(0, 1)), N'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
Command-driven control stage that sits directly upstream of the team's N-bit universal shift register. It accepts queued commands (load, shift, rotate, hold) over a valid/ready handshake and expands each one into the per-cycle control pattern the register consumes: l, r, serial input i and parallel data d. For rotates, the register's q output is fed back into the sequencer. A done pulse marks each command's completion.

Parameters:
N, 8, width of the driven shift register and of cmd_data/d/q_fb
CW, $clog2(N)+1, width of cmd_cnt (counts 0..2^CW-1)

Ports:
c  input  1  clock, rising edge
rst  input  1  synchronous reset, active high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted on an edge where cmd_valid&cmd_ready
cmd_op  input  3  0 HOLD, 1 LOAD, 2 SHU, 3 SHD, 4 ROU, 5 ROD; 6,7 treated as HOLD
cmd_cnt  input  CW  number of shift/rotate steps
cmd_fill  input  1  serial fill bit for SHU/SHD
cmd_data  input  N  parallel load value for LOAD
q_fb  input  N  current register contents (rotate feedback)
l  output  1  register control
r  output  1  register control
i  output  1  register serial input
d  output  N  register parallel input
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse

Behaviour:
- Register control contract: l=1,r=1 load d; l=1,r=0 shift toward LSB with i entering the MSB (SHD); l=0,r=1 shift toward MSB with i entering the LSB (SHU); l=0,r=0 hold.
- States: IDLE and RUN. Remaining-step counter rem, CW bits.
- cmd_ready = !rst & (IDLE | (RUN & rem==1)). This is combinational and gives zero-bubble back-to-back commands.
- Acceptance at edge T:
  - LOAD: state becomes RUN with rem=1. In cycle T+1, l=r=1 and d=cmd_data. cmd_cnt is ignored.
  - SHU/SHD/ROU/ROD with cnt>0: state becomes RUN with rem=cnt. Controls are driven in cycles T+1..T+cnt.
  - HOLD, illegal op, or shift/rotate with cnt=0: state stays IDLE. No control cycles; done=1 in T+1.
- l, r, d and the fill bit are registered at acceptance and remain stable for the whole command.
- i source:
  - SHU/SHD: registered cmd_fill.
  - ROU: combinational q_fb[N-1].
  - ROD: combinational q_fb[0].
  - LOAD/idle: 0.
- Each RUN edge decrements rem. At the edge where rem==1:
  - If a command is accepted on that same edge, the new command's controls apply from the next cycle.
  - Otherwise state returns to IDLE and outputs return to hold (l=r=i=0; d keeps its value).
  - In both cases done=1 in the following cycle. done is a registered pulse, exactly one cycle per command.
- Consequence: a k-step command accepted at edge T asserts done in cycle T+k+1.
- cnt values larger than N are executed literally, with no clamping.
- busy = (state==RUN).
- Reset (sync, edge with rst=1):
  - Values: state=IDLE, rem=0, l=r=i=0, d=0, done=0, busy=0.
  - cmd_ready is 0 while rst is high.
  - Reset mid-RUN aborts the command with no done pulse; the register keeps its partial result.
- cmd_valid while not ready: the command is held by upstream and not sampled. Inputs may change freely while cmd_valid=0.

Decomposition:
- Shared package: the op enum (HOLD, LOAD, SHU, SHD, ROU, ROD) and the state enum {IDLE, RUN}.
- Sub-module: one natural candidate is shift_step_counter (loadable down-counter with a last-step flag, CW bits).
- The FSM, control registers and i mux stay in the top module.

Test Plan:
The bench instantiates the universal shift register with N=8, driven by l/r/i/d, with q looped to q_fb.
- Reset: hold rst=1 for 2 edges -> l=r=i=0, d=0, busy=0, done=0, cmd_ready=0 during reset, cmd_ready=1 after.
- LOAD 0xA5 -> exactly one cycle of l=r=1 with d=0xA5; q=0xA5; done one cycle later; busy high for one cycle.
- From 0xA5, SHD cnt=3 fill=1 -> three cycles of l=1,r=0,i=1; q=0xF4; done in cycle T+4.
- From 0xA5, ROU cnt=3 -> q steps 0x4B, 0x96, 0x2D; i follows q_fb[7] each cycle.
- Back-to-back: SHU cnt=2 fill=0 then LOAD 0x3C with valid held -> LOAD accepted on the final SHU edge with no hold cycle between; two done pulses; final q=0x3C.
- Edge cases:
  - HOLD, and SHD cnt=0 -> no l/r activity, done next cycle.
  - SHD cnt=8 with rst pulsed on the 3rd RUN cycle -> controls drop to hold, no done, q retains its partial value.
